// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, selects the next PC from JumpOP and
// paces each instruction through a fetch handshake followed by a one-cycle execute.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  JumpOP,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   input  logic [31:0] rs_data,
   input  logic        halt,
   input  logic        im_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        im_req,
   output logic        instr_valid,
   output logic        halted,
   output logic [31:0] retire_cnt
);

   localparam int unsigned PC_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_d, cnt_d, next_pc, br_off;
   logic             im_req_d, instr_valid_d, halted_d;

   assign pc_plus4 = pc + PC_W'(4);
   assign br_off   = {{14{imm[15]}}, imm, 2'b00};

   // Next-PC select; all arithmetic wraps silently
   always_comb begin
      next_pc = pc_plus4;
      case (JumpOP)
         2'b00: next_pc = pc_plus4;
         2'b01: next_pc = pc_plus4 + br_off;
         2'b10: next_pc = rs_data & 32'hFFFF_FFFC;
         2'b11: next_pc = {pc_plus4[31:28], target, 2'b00};
         default: next_pc = pc_plus4;
      endcase
   end

   // Next-state, PC/counter update and next-output decode
   always_comb begin
      state_d = state_q;
      pc_d    = pc;
      cnt_d   = retire_cnt;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: if (im_ready) state_d = EXEC;
         EXEC: begin
            pc_d    = next_pc;
            cnt_d   = retire_cnt + PC_W'(1);
            state_d = halt ? HALT : FETCH;
         end
         HALT:  state_d = HALT;
         default: state_d = IDLE;
      endcase
      im_req_d      = (state_d == FETCH);
      instr_valid_d = (state_d == EXEC);
      halted_d      = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pc          <= RESET_PC;
         retire_cnt  <= '0;
         im_req      <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc          <= pc_d;
         retire_cnt  <= cnt_d;
         im_req      <= im_req_d;
         instr_valid <= instr_valid_d;
         halted      <= halted_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; samples on the falling edge.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic [1:0]  JumpOP;
   logic [15:0] imm;
   logic [25:0] target;
   logic [31:0] rs_data;
   logic        halt;
   logic        im_ready;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        im_req;
   logic        instr_valid;
   logic        halted;
   logic [31:0] retire_cnt;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] cur_pc;
   logic [31:0] exp_ret;

   pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .JumpOP(JumpOP), .imm(imm), .target(target),
      .rs_data(rs_data), .halt(halt), .im_ready(im_ready), .pc(pc),
      .pc_plus4(pc_plus4), .im_req(im_req), .instr_valid(instr_valid),
      .halted(halted), .retire_cnt(retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Values that must be ignored while not in EXEC
   task automatic drive_junk();
      JumpOP  = 2'b11;
      imm     = 16'h8000;
      target  = 26'h3FF_FFFF;
      rs_data = 32'hDEAD_BEEF;
      halt    = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pc"},    pc, 32'h0);
      chk({tag, "_pc4"},   pc_plus4, 32'h4);
      chk({tag, "_req"},   32'(im_req), 32'h0);
      chk({tag, "_vld"},   32'(instr_valid), 32'h0);
      chk({tag, "_hlt"},   32'(halted), 32'h0);
      chk({tag, "_ret"},   retire_cnt, 32'h0);
   endtask

   // Called at a falling edge while in FETCH; returns at the falling edge after EXEC
   task automatic do_instr(input logic [1:0] jop, input logic [15:0] im, input logic [25:0] tg,
                           input logic [31:0] rs, input logic h, input int stall,
                           input logic [31:0] exp_next);
      chk("fetch_req", 32'(im_req), 32'h1);
      chk("fetch_pc", pc, cur_pc);
      drive_junk();
      im_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_req", 32'(im_req), 32'h1);
         chk("stall_vld", 32'(instr_valid), 32'h0);
         chk("stall_pc", pc, cur_pc);
      end
      im_ready = 1'b1;
      @(negedge clk);
      chk("exec_vld", 32'(instr_valid), 32'h1);
      chk("exec_req", 32'(im_req), 32'h0);
      chk("exec_pc", pc, cur_pc);
      JumpOP = jop; imm = im; target = tg; rs_data = rs; halt = h;
      im_ready = 1'b1;
      @(negedge clk);
      drive_junk();
      im_ready = 1'b0;
      exp_ret = exp_ret + 32'd1;
      cur_pc  = exp_next;
      chk("next_pc", pc, exp_next);
      chk("next_pc4", pc_plus4, exp_next + 32'd4);
      chk("retire", retire_cnt, exp_ret);
   endtask

   task automatic release_reset();
      rst = 1'b1;
      #1;
      chk("idle_req", 32'(im_req), 32'h0);
      @(negedge clk);
      chk("first_req", 32'(im_req), 32'h1);
      cur_pc  = 32'h0;
      exp_ret = 32'h0;
   endtask

   initial begin
      rst = 1'b0;
      im_ready = 1'b1;
      drive_junk();
      cur_pc = 32'h0;
      exp_ret = 32'h0;
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      release_reset();

      // Sequential 0,4,8,12 -> 16
      for (int i = 0; i < 4; i++)
         do_instr(2'b00, 16'h0, 26'h0, 32'h0, 1'b0, 0, 32'(i * 4 + 4));
      chk("seq_retire", retire_cnt, 32'd4);

      // Branches both directions, low bits of rs forced to zero
      do_instr(2'b10, 16'h0, 26'h0, 32'h0000_0103, 1'b0, 0, 32'h0000_0100);
      do_instr(2'b01, 16'h0003, 26'h0, 32'h0, 1'b0, 0, 32'h0000_0110);
      do_instr(2'b01, 16'hFFFE, 26'h0, 32'h0, 1'b0, 0, 32'h0000_010C);

      // J-type and jump register
      do_instr(2'b10, 16'h0, 26'h0, 32'h4000_0010, 1'b0, 0, 32'h4000_0010);
      do_instr(2'b11, 16'h0, 26'h0000040, 32'h0, 1'b0, 0, 32'h4000_0100);
      do_instr(2'b10, 16'h0, 26'h0, 32'h0000_2003, 1'b0, 0, 32'h0000_2000);

      // Three stall cycles in FETCH
      do_instr(2'b00, 16'h0, 26'h0, 32'h0, 1'b0, 3, 32'h0000_2004);

      // Wrap-around
      do_instr(2'b10, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, 1, 32'hFFFF_FFFC);
      do_instr(2'b00, 16'h0, 26'h0, 32'h0, 1'b0, 0, 32'h0000_0000);

      // Halt at 0x20 -> 0x24 then frozen
      do_instr(2'b10, 16'h0, 26'h0, 32'h0000_0020, 1'b0, 0, 32'h0000_0020);
      do_instr(2'b00, 16'h0, 26'h0, 32'h0, 1'b1, 0, 32'h0000_0024);
      chk("halted", 32'(halted), 32'h1);
      im_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_req", 32'(im_req), 32'h0);
         chk("halt_vld", 32'(instr_valid), 32'h0);
         chk("halt_pc", pc, 32'h0000_0024);
         chk("halt_ret", retire_cnt, exp_ret);
      end

      // Reset out of HALT, between edges
      #2;
      rst = 1'b0;
      #1;
      check_reset_vals("rst_halt");
      @(negedge clk);
      release_reset();

      // Reset mid-FETCH after a jump, between edges
      do_instr(2'b10, 16'h0, 26'h0, 32'h0000_0040, 1'b0, 1, 32'h0000_0040);
      im_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check_reset_vals("rst_fetch");
      @(negedge clk);
      check_reset_vals("rst_hold");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
